exu_alu_share_arb: RTL and testbench
====================================

Name: exu_alu_share_arb

Overview:
Arbitrates NREQ requesters (late-issue/auxiliary ops) onto one shared integer ALU, sequences operands through a two-stage pipeline, and returns tagged results over a valid/ready handshake. Sits in the EXU beside the main ALU pipes and honours the pipeline freeze and flush controls. Round-robin fairness, one issue per cycle, full throughput when the consumer is ready.

Parameters:
NREQ, 2, number of requesters (2..8)
TAGW, 4, width of opaque requester tag returned with result
IDW, max(1,$clog2(NREQ)), width of requester index

Ports:
clk  in  1  top-level clock
rst  in  1  asynchronous active-high reset
freeze  in  1  pipeline freeze; all state holds
flush  in  1  pipeline flush; kills pending and in-flight ops
req  in  NREQ  per-requester request
op  in  NREQ*4  per-requester alu_op_e
a  in  NREQ*32  per-requester operand A
b  in  NREQ*32  per-requester operand B
tag  in  NREQ*TAGW  per-requester tag
gnt  out  NREQ  one-hot grant (combinational); req&gnt = accepted
rsp_valid  out  1  result valid
rsp_ready  in  1  consumer accepts result
rsp_id  out  IDW  index of requester owning result
rsp_tag  out  TAGW  tag of result
rsp_data  out  32  ALU result
busy  out  1  s1_valid | rsp_valid

Behaviour:
- Reset (async, rst=1): s1_valid=0, rsp_valid=0, rsp_id/rsp_tag/rsp_data=0, rr_ptr=0; gnt=0 while rst=1.
- Pipeline: cycle N grant; N+1 operands in S1 register, ALU evaluated combinationally; N+2 result in output register (rsp_*). Latency grant->rsp_valid = 2 cycles.
- out_free = ~rsp_valid | rsp_ready. s1_adv = s1_valid & out_free. s1_free = ~s1_valid | s1_adv.
- can_issue = ~rst & ~freeze & ~flush & s1_free. gnt is zero when ~can_issue, else one-hot to first requesting index at or after rr_ptr (wrapping modulo NREQ); zero when no req.
- On grant to i: S1 <= {op_i,a_i,b_i,tag_i,i}, s1_valid<=1; rr_ptr <= (i+1) mod NREQ (wrap NREQ-1 -> 0). No grant: rr_ptr holds.
- s1_adv: output regs <= ALU result, rsp_valid<=1; else if rsp_valid&rsp_ready: rsp_valid<=0. If s1_valid & ~s1_adv & no grant, S1 holds.
- Requester may drop or change req/op/a/b/tag any cycle without grant; no stickiness.
- ALU ops (alu_op_e): ADD a+b; SUB a-b; SLT signed a<b ->{31'b0,1}; SLTU unsigned; AND; OR; XOR; SLL a<<b[4:0]; SRL logical; SRA arithmetic; undefined encodings -> 0. All mod 2^32, no exceptions.
- freeze=1: gnt=0; S1, output regs, rr_ptr hold; rsp_ready ignored (no transfer completes); rsp_valid held.
- flush=1 (priority over freeze and rsp_ready): gnt=0; next cycle s1_valid=0, rsp_valid=0; rr_ptr holds; a response presented in the flush cycle is discarded even if rsp_ready=1.
- Full throughput: with rsp_ready=1 continuously and requests present, one grant and one response per cycle.
- Backpressure: rsp_valid&~rsp_ready with s1_valid=1 -> no grant until output drains; at most 2 ops in flight.
- rsp_* stable while rsp_valid&~rsp_ready.
- Reset mid-operation discards all in-flight ops immediately.

Decomposition:
- Shared package (veer_types): typedef enum logic[3:0] alu_op_e {ADD=0,SUB=1,SLT=2,SLTU=3,AND=4,OR=5,XOR=6,SLL=7,SRL=8,SRA=9}; typedef struct alu_share_s1_t {alu_op_e op; logic[31:0] a,b; tag; id}.
- Sub-module exu_alu_core: purely combinational op,a,b -> 32-bit result (subtract via invert+carry-in, overflow-based signed compare, carry-based unsigned compare).
- Arbiter, S1/output registers (rvdff-style primitives with async clear) in top.

Test Plan:
- Single: req[0], op=ADD, a=32'h7FFF_FFFF, b=1, tag=5 -> gnt[0] same cycle; 2 cycles later rsp_valid=1, rsp_data=32'h8000_0000, rsp_id=0, rsp_tag=5.
- Round-robin: req=2'b11 held 4 cycles, rsp_ready=1 -> gnt sequence 01,10,01,10; rsp_id 0,1,0,1 in consecutive cycles.
- Compare/shift: SLT a=32'hFFFF_FFFF,b=1 -> 1; SLTU same -> 0; SRA a=32'h8000_0000,b=4 -> 32'hF800_0000; SUB 3-5 -> 32'hFFFF_FFFE.
- Backpressure: 3 back-to-back ops, rsp_ready=0 for 3 cycles -> 2 grants then gnt=0, rsp_* stable; rsp_ready=1 -> drains in order, third granted when S1 frees.
- Flush: op in S1 and result pending, flush=1 with rsp_ready=1 -> gnt=0, next cycle rsp_valid=0, busy=0; no response for either op.
- Freeze then reset: freeze=1 with rsp_valid=1, rsp_ready=1 for 3 cycles -> rsp_valid stays 1, gnt=0; assert rst mid-freeze -> rsp_valid=0, rr_ptr=0 immediately.

Source files
------------

// File: rtl/exu_alu_share_arb_pkg.sv
// Shared types for the EXU auxiliary-op ALU share arbiter: ALU opcode encoding
// and the operand record held in the S1 pipeline register.
package exu_alu_share_arb_pkg;

  typedef enum logic [3:0] {
    ALU_ADD  = 4'd0,
    ALU_SUB  = 4'd1,
    ALU_SLT  = 4'd2,
    ALU_SLTU = 4'd3,
    ALU_AND  = 4'd4,
    ALU_OR   = 4'd5,
    ALU_XOR  = 4'd6,
    ALU_SLL  = 4'd7,
    ALU_SRL  = 4'd8,
    ALU_SRA  = 4'd9
  } alu_op_e;

  typedef struct packed {
    alu_op_e     op;
    logic [31:0] a;
    logic [31:0] b;
  } alu_share_s1_t;

endpackage

// File: rtl/exu_alu_share_arb_core.sv
// Purely combinational 32-bit integer ALU used by the shared auxiliary pipe.
module exu_alu_share_arb_core
  import exu_alu_share_arb_pkg::*;
(
  input  alu_op_e     op,
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic [31:0] result
);

  logic [32:0]        diff_c;
  logic               ovf;
  logic               lt_s;
  logic               lt_u;
  logic [4:0]         shamt;
  logic signed [31:0] a_s;

  // One subtractor serves SUB and both compares: carry-out clear means a < b unsigned.
  assign diff_c = {1'b0, a} + {1'b0, ~b} + 33'd1;
  assign ovf    = (a[31] ^ b[31]) & (diff_c[31] ^ a[31]);
  assign lt_s   = diff_c[31] ^ ovf;
  assign lt_u   = ~diff_c[32];
  assign shamt  = b[4:0];
  assign a_s    = a;

  always_comb begin
    result = '0;
    case (op)
      ALU_ADD:  result = a + b;
      ALU_SUB:  result = diff_c[31:0];
      ALU_SLT:  result = {31'b0, lt_s};
      ALU_SLTU: result = {31'b0, lt_u};
      ALU_AND:  result = a & b;
      ALU_OR:   result = a | b;
      ALU_XOR:  result = a ^ b;
      ALU_SLL:  result = a << shamt;
      ALU_SRL:  result = a >> shamt;
      ALU_SRA:  result = a_s >>> shamt;
      default:  result = '0;
    endcase
  end

endmodule

// File: rtl/exu_alu_share_arb.sv
// Round-robin arbiter feeding NREQ auxiliary requesters into one shared ALU
// through a two-stage (S1, output) pipeline with valid/ready result return.
module exu_alu_share_arb
  import exu_alu_share_arb_pkg::*;
#(
  parameter int NREQ = 2,
  parameter int TAGW = 4,
  parameter int IDW  = (NREQ > 1) ? $clog2(NREQ) : 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 freeze,
  input  logic                 flush,
  input  logic [NREQ-1:0]      req,
  input  logic [NREQ*4-1:0]    op,
  input  logic [NREQ*32-1:0]   a,
  input  logic [NREQ*32-1:0]   b,
  input  logic [NREQ*TAGW-1:0] tag,
  output logic [NREQ-1:0]      gnt,
  output logic                 rsp_valid,
  input  logic                 rsp_ready,
  output logic [IDW-1:0]       rsp_id,
  output logic [TAGW-1:0]      rsp_tag,
  output logic [31:0]          rsp_data,
  output logic                 busy
);

  alu_share_s1_t   s1_q, s1_d;
  logic [TAGW-1:0] s1_tag_q, s1_tag_d;
  logic [IDW-1:0]  s1_id_q, s1_id_d;
  logic            s1_valid_q, s1_valid_d;
  logic            rsp_valid_q, rsp_valid_d;
  logic [IDW-1:0]  rsp_id_q, rsp_id_d;
  logic [TAGW-1:0] rsp_tag_q, rsp_tag_d;
  logic [31:0]     rsp_data_q, rsp_data_d;
  logic [IDW-1:0]  rr_ptr_q, rr_ptr_d;

  logic            out_free, s1_adv, s1_free, can_issue;
  logic            gnt_any;
  logic [IDW-1:0]  gnt_id;
  alu_share_s1_t   sel_ops;
  logic [TAGW-1:0] sel_tag;
  logic [31:0]     alu_res;

  assign out_free  = ~rsp_valid_q | rsp_ready;
  assign s1_adv    = s1_valid_q & out_free;
  assign s1_free   = ~s1_valid_q | s1_adv;
  assign can_issue = ~rst & ~freeze & ~flush & s1_free;

  // Search starts at rr_ptr and wraps, so the last winner has lowest priority.
  always_comb begin
    int idx;
    gnt     = '0;
    gnt_any = 1'b0;
    gnt_id  = '0;
    idx     = 0;
    if (can_issue) begin
      for (int k = 0; k < NREQ; k++) begin
        idx = int'(rr_ptr_q) + k;
        if (idx >= NREQ) idx = idx - NREQ;
        if (!gnt_any && req[idx]) begin
          gnt_any = 1'b1;
          gnt_id  = IDW'(idx);
        end
      end
    end
    if (gnt_any) gnt[gnt_id] = 1'b1;
  end

  always_comb begin
    sel_ops = '0;
    sel_tag = '0;
    for (int k = 0; k < NREQ; k++) begin
      if (gnt[k]) begin
        sel_ops.op = alu_op_e'(op[k*4 +: 4]);
        sel_ops.a  = a[k*32 +: 32];
        sel_ops.b  = b[k*32 +: 32];
        sel_tag    = tag[k*TAGW +: TAGW];
      end
    end
  end

  exu_alu_share_arb_core u_core (
    .op     (s1_q.op),
    .a      (s1_q.a),
    .b      (s1_q.b),
    .result (alu_res)
  );

  always_comb begin
    s1_d        = s1_q;
    s1_tag_d    = s1_tag_q;
    s1_id_d     = s1_id_q;
    s1_valid_d  = s1_valid_q;
    rsp_valid_d = rsp_valid_q;
    rsp_id_d    = rsp_id_q;
    rsp_tag_d   = rsp_tag_q;
    rsp_data_d  = rsp_data_q;
    rr_ptr_d    = rr_ptr_q;
    // Flush wins over freeze and over a handshake completing this cycle.
    if (flush) begin
      s1_valid_d  = 1'b0;
      rsp_valid_d = 1'b0;
    end else if (!freeze) begin
      if (s1_adv) begin
        rsp_valid_d = 1'b1;
        rsp_data_d  = alu_res;
        rsp_id_d    = s1_id_q;
        rsp_tag_d   = s1_tag_q;
      end else if (rsp_valid_q && rsp_ready) begin
        rsp_valid_d = 1'b0;
      end
      if (gnt_any) begin
        s1_d       = sel_ops;
        s1_tag_d   = sel_tag;
        s1_id_d    = gnt_id;
        s1_valid_d = 1'b1;
        rr_ptr_d   = (gnt_id == IDW'(NREQ - 1)) ? '0 : gnt_id + 1'b1;
      end else if (s1_adv) begin
        s1_valid_d = 1'b0;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_q        <= '0;
      s1_tag_q    <= '0;
      s1_id_q     <= '0;
      s1_valid_q  <= 1'b0;
      rsp_valid_q <= 1'b0;
      rsp_id_q    <= '0;
      rsp_tag_q   <= '0;
      rsp_data_q  <= '0;
      rr_ptr_q    <= '0;
    end else begin
      s1_q        <= s1_d;
      s1_tag_q    <= s1_tag_d;
      s1_id_q     <= s1_id_d;
      s1_valid_q  <= s1_valid_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_id_q    <= rsp_id_d;
      rsp_tag_q   <= rsp_tag_d;
      rsp_data_q  <= rsp_data_d;
      rr_ptr_q    <= rr_ptr_d;
    end
  end

  assign rsp_valid = rsp_valid_q;
  assign rsp_id    = rsp_id_q;
  assign rsp_tag   = rsp_tag_q;
  assign rsp_data  = rsp_data_q;
  assign busy      = s1_valid_q | rsp_valid_q;

endmodule

// File: tb/tb_exu_alu_share_arb.sv
// Randomized and directed bench for exu_alu_share_arb against a queue-based
// transaction model of the two-slot result pipeline.
module tb_exu_alu_share_arb;

  localparam int NREQ = 3;
  localparam int TAGW = 4;
  localparam int IDW  = 2;

  logic                 clk = 1'b0;
  logic                 rst, freeze, flush, rsp_ready;
  logic [NREQ-1:0]      req;
  logic [NREQ*4-1:0]    op;
  logic [NREQ*32-1:0]   a, b;
  logic [NREQ*TAGW-1:0] tag;
  logic [NREQ-1:0]      gnt;
  logic                 rsp_valid, busy;
  logic [IDW-1:0]       rsp_id;
  logic [TAGW-1:0]      rsp_tag;
  logic [31:0]          rsp_data;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [31:0]     data;
    int              id;
    logic [TAGW-1:0] tg;
  } item_t;

  item_t q[$];
  bit    out_full;
  int    rr;

  always #5 clk = ~clk;

  exu_alu_share_arb #(.NREQ(NREQ), .TAGW(TAGW), .IDW(IDW)) dut (
    .clk(clk), .rst(rst), .freeze(freeze), .flush(flush),
    .req(req), .op(op), .a(a), .b(b), .tag(tag), .gnt(gnt),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id),
    .rsp_tag(rsp_tag), .rsp_data(rsp_data), .busy(busy)
  );

  task automatic check_val(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h at %0t", name, got, exp, $time);
    end
  endtask

  function automatic logic [31:0] alu_ref(input logic [3:0] o, input logic [31:0] x, input logic [31:0] y);
    int sh;
    sh = int'(y % 32);
    case (o)
      4'd0: return x + y;
      4'd1: return x - y;
      4'd2: return ($signed(x) < $signed(y)) ? 32'd1 : 32'd0;
      4'd3: return (x < y) ? 32'd1 : 32'd0;
      4'd4: return x & y;
      4'd5: return x | y;
      4'd6: return x ^ y;
      4'd7: return x << sh;
      4'd8: return x >> sh;
      4'd9: return $unsigned($signed(x) >>> sh);
      default: return 32'd0;
    endcase
  endfunction

  function automatic int exp_winner();
    bit s1_item, s1_free;
    s1_item = q.size() > int'(out_full);
    s1_free = !s1_item || !out_full || rsp_ready;
    if (rst || freeze || flush || !s1_free) return -1;
    for (int k = 0; k < NREQ; k++)
      if (req[(rr + k) % NREQ]) return (rr + k) % NREQ;
    return -1;
  endfunction

  task automatic model_reset();
    q.delete();
    out_full = 1'b0;
    rr = 0;
  endtask

  task automatic set_req(input int i, input logic [3:0] o, input logic [31:0] x,
                         input logic [31:0] y, input logic [TAGW-1:0] t);
    op[i*4 +: 4]       = o;
    a[i*32 +: 32]      = x;
    b[i*32 +: 32]      = y;
    tag[i*TAGW +: TAGW] = t;
  endtask

  // Compare outputs mid-cycle, advance the model by one edge, return at edge+1.
  task automatic tick();
    int w;
    logic [NREQ-1:0] eg;
    bit s1_item, adv;
    item_t it;
    #2;
    w  = exp_winner();
    eg = '0;
    if (w >= 0) eg[w] = 1'b1;
    check_val("gnt", gnt, eg);
    check_val("rsp_valid", rsp_valid, out_full);
    check_val("busy", busy, q.size() != 0);
    if (out_full) begin
      check_val("rsp_data", rsp_data, q[0].data);
      check_val("rsp_id", rsp_id, q[0].id);
      check_val("rsp_tag", rsp_tag, q[0].tg);
    end
    if (flush) begin
      q.delete();
      out_full = 1'b0;
    end else if (!freeze) begin
      s1_item = q.size() > int'(out_full);
      adv     = s1_item && (!out_full || rsp_ready);
      if (out_full && rsp_ready) begin
        void'(q.pop_front());
        out_full = 1'b0;
      end
      if (adv) out_full = 1'b1;
      if (w >= 0) begin
        it.data = alu_ref(op[w*4 +: 4], a[w*32 +: 32], b[w*32 +: 32]);
        it.id   = w;
        it.tg   = tag[w*TAGW +: TAGW];
        q.push_back(it);
        rr = (w + 1) % NREQ;
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic tick_g(input logic [NREQ-1:0] eg);
    #1;
    check_val("gnt_lit", gnt, eg);
    tick();
  endtask

  task automatic single_op(input logic [3:0] o, input logic [31:0] x, input logic [31:0] y,
                           input logic [31:0] exp);
    req = 3'b001;
    set_req(0, o, x, y, 4'(o));
    tick_g(3'b001);
    req = '0;
    tick();
    check_val("op_result", rsp_data, exp);
    tick();
  endtask

  initial begin
    rst = 1'b1; freeze = 1'b0; flush = 1'b0; rsp_ready = 1'b1;
    req = '1; op = '0; a = '0; b = '0; tag = '0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check_val("rst_gnt", gnt, 0);
    check_val("rst_rsp_valid", rsp_valid, 0);
    check_val("rst_rsp_data", rsp_data, 0);
    check_val("rst_busy", busy, 0);
    rst = 1'b0;
    req = '0;

    // Single ADD with overflow into the sign bit
    req = 3'b001;
    set_req(0, 4'd0, 32'h7FFF_FFFF, 32'd1, 4'd5);
    tick_g(3'b001);
    req = '0;
    tick();
    check_val("single_valid", rsp_valid, 1);
    check_val("single_data", rsp_data, 32'h8000_0000);
    check_val("single_id", rsp_id, 0);
    check_val("single_tag", rsp_tag, 5);
    tick();

    single_op(4'd2, 32'hFFFF_FFFF, 32'd1, 32'd1);
    single_op(4'd3, 32'hFFFF_FFFF, 32'd1, 32'd0);
    single_op(4'd9, 32'h8000_0000, 32'd4, 32'hF800_0000);
    single_op(4'd1, 32'd3, 32'd5, 32'hFFFF_FFFE);
    tick();

    // Round robin: park the pointer at 0 via requester 2, then alternate 0/1
    req = 3'b100;
    set_req(2, 4'd4, 32'hF0F0, 32'hFF00, 4'd2);
    tick_g(3'b100);
    req = 3'b011;
    set_req(0, 4'd0, 32'd10, 32'd20, 4'd7);
    set_req(1, 4'd6, 32'hAAAA, 32'h5555, 4'd9);
    tick_g(3'b001);
    tick_g(3'b010);
    tick_g(3'b001);
    tick_g(3'b010);
    req = '0;
    repeat (3) tick();

    // Backpressure: two ops in flight, then drain and admit the third
    rsp_ready = 1'b0;
    req = 3'b001;
    set_req(0, 4'd7, 32'h1234_5678, 32'd8, 4'd1);
    tick_g(3'b001);
    set_req(0, 4'd8, 32'h8765_4321, 32'd12, 4'd2);
    tick_g(3'b001);
    set_req(0, 4'd5, 32'h00FF_0000, 32'h0000_00FF, 4'd3);
    tick_g(3'b000);
    tick_g(3'b000);
    check_val("bp_hold_data", rsp_data, 32'h3456_7800);
    rsp_ready = 1'b1;
    tick_g(3'b001);
    req = '0;
    repeat (3) tick();

    // Flush with S1 occupied and a result presented
    rsp_ready = 1'b0;
    req = 3'b001;
    set_req(0, 4'd0, 32'd1, 32'd2, 4'd4);
    tick();
    tick();
    flush = 1'b1;
    rsp_ready = 1'b1;
    tick_g(3'b000);
    flush = 1'b0;
    req = '0;
    check_val("flush_valid", rsp_valid, 0);
    check_val("flush_busy", busy, 0);
    repeat (2) tick();

    // Freeze holding a result, then reset in the middle of the freeze
    rsp_ready = 1'b0;
    req = 3'b001;
    set_req(0, 4'd4, 32'hFFFF_0000, 32'h0F0F_0F0F, 4'd6);
    tick();
    req = '0;
    tick();
    freeze = 1'b1;
    rsp_ready = 1'b1;
    req = 3'b011;
    repeat (3) tick_g(3'b000);
    check_val("freeze_valid", rsp_valid, 1);
    rst = 1'b1;
    #1;
    check_val("midrst_valid", rsp_valid, 0);
    check_val("midrst_busy", busy, 0);
    check_val("midrst_gnt", gnt, 0);
    model_reset();
    @(posedge clk);
    #1;
    rst = 1'b0;
    freeze = 1'b0;
    req = 3'b111;
    tick_g(3'b001);
    req = '0;
    repeat (3) tick();

    // Random traffic
    for (int n = 0; n < 600; n++) begin
      req       = NREQ'($urandom);
      op        = NREQ*4'($urandom);
      for (int i = 0; i < NREQ; i++) begin
        a[i*32 +: 32] = $urandom;
        b[i*32 +: 32] = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 40)) : $urandom;
        tag[i*TAGW +: TAGW] = TAGW'($urandom);
        if ($urandom_range(0, 2) == 0) op[i*4 +: 4] = 4'($urandom_range(0, 9));
      end
      rsp_ready = ($urandom_range(0, 9) < 7);
      freeze    = ($urandom_range(0, 9) == 0);
      flush     = ($urandom_range(0, 24) == 0);
      tick();
    end
    freeze = 1'b0; flush = 1'b0; req = '0; rsp_ready = 1'b1;
    repeat (3) tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout got=running exp=finished");
    $fatal(1, "timeout");
  end

endmodule
